// File: rtl/noc_flit_pkg.sv
// Shared flit definitions for the ring sensor network interfaces:
// flit type codes, head field layout, payload widths, FSM encoding
// and small flit-building helpers.
package noc_flit_pkg;

  // Flit geometry
  localparam int FlitW    = 32;
  localparam int PayloadW = 24;
  localparam int IdW      = 4;
  localparam int PortW    = 5;
  localparam int SeqW     = 8;

  // Flit type codes live in the two top bits of every flit
  localparam logic [1:0] FLIT_HEAD = 2'b00;
  localparam logic [1:0] FLIT_BODY = 2'b01;
  localparam logic [1:0] FLIT_TAIL = 2'b11;

  // Head field positions (LSB of each field)
  localparam int HeadPortLsb = 0;
  localparam int HeadIdLsb   = HeadPortLsb + PortW;

  // Interface FSM states
  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_HEAD = 3'd1,
    ST_BODY = 3'd2,
    ST_TAIL = 3'd3,
    ST_PASS = 3'd4
  } ni_state_e;

  // Head flit: type, marker bit, reserved zeros, source ID, destination port
  function automatic logic [FlitW-1:0] make_head(input logic [IdW-1:0]   id,
                                                 input logic [PortW-1:0] port);
    make_head = {FLIT_HEAD, 1'b1, 19'b0, 1'b0, id, port};
  endfunction

  // Body flit: type, reserved zeros, full 24-bit sample
  function automatic logic [FlitW-1:0] make_body(input logic [PayloadW-1:0] sample);
    make_body = {FLIT_BODY, 6'b0, sample};
  endfunction

  // Tail flit: type, reserved zeros, round sequence number, sample low byte
  function automatic logic [FlitW-1:0] make_tail(input logic [SeqW-1:0] seq,
                                                 input logic [7:0]      sample_lo);
    make_tail = {FLIT_TAIL, 14'b0, seq, sample_lo};
  endfunction

endpackage

// File: rtl/ni_next_ch_sel.sv
// Combinational priority finder over the channel enable mask.
// Returns the lowest enabled channel strictly above i_cur, or the lowest
// enabled channel overall when i_from_start is set (search "from -1").
module ni_next_ch_sel #(
  parameter int NumCh = 2,
  parameter int IdxW  = 1
) (
  input  logic [NumCh-1:0] i_mask,
  input  logic [IdxW-1:0]  i_cur,
  input  logic             i_from_start,
  output logic [IdxW-1:0]  o_idx,
  output logic             o_found
);

  logic [NumCh-1:0] w_qual;

  // Qualify each channel, then scan high-to-low so the lowest qualifying wins
  always_comb begin
    w_qual  = '0;
    o_idx   = '0;
    o_found = 1'b0;
    for (int k = NumCh - 1; k >= 0; k--) begin
      w_qual[k] = i_mask[k] & (i_from_start | (IdxW'(k) > i_cur));
      o_idx     = w_qual[k] ? IdxW'(k) : o_idx;
      o_found   = o_found | w_qual[k];
    end
  end

endmodule

// File: rtl/sensor_ni_multi.sv
// Multi-channel ring sensor network interface. On token arrival it
// snapshots all channels and the enable mask, emits one head/body/tail
// packet per enabled channel, then releases the token. A round sequence
// number travels in each tail flit and advances once per sending round.
module sensor_ni_multi
  import noc_flit_pkg::*;
#(
  parameter int                 NumCh    = 2,
  parameter int                 DataW    = 24,
  parameter logic [NumCh*5-1:0] DstPorts = {5'd26, 5'd27}
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [NumCh*DataW-1:0] Data_i,
  input  logic [NumCh-1:0]       ChEn_i,
  input  logic [IdW-1:0]         ID_i,
  output logic                   Valid_o,
  output logic [FlitW-1:0]       Data_o,
  input  logic                   Ready_i,
  input  logic                   TokenValid_i,
  output logic                   TokenValid_o,
  output logic                   Busy_o
);

  localparam int IdxW = (NumCh > 1) ? $clog2(NumCh) : 1;

  // Registered state
  ni_state_e              r_state;
  logic [IdxW-1:0]        r_idx;
  logic [SeqW-1:0]        r_seq;
  logic [NumCh*DataW-1:0] r_data;
  logic [NumCh-1:0]       r_mask;

  // Next-state and output nets
  ni_state_e              w_state_nxt;
  logic [IdxW-1:0]        w_idx_nxt;
  logic [SeqW-1:0]        w_seq_nxt;
  logic                   w_cap;
  logic                   w_valid;
  logic [FlitW-1:0]       w_data;
  logic                   w_tv;

  // Channel selector interface
  logic [NumCh-1:0]       w_sel_mask;
  logic                   w_sel_from_start;
  logic [IdxW-1:0]        w_sel_idx;
  logic                   w_sel_found;

  // Current channel fields
  logic [PayloadW-1:0]    w_sample;
  logic [PortW-1:0]       w_port;

  // In IDLE the search runs on the live mask being captured; afterwards on
  // the snapshot, continuing above the channel just sent.
  assign w_sel_from_start = (r_state == ST_IDLE);
  assign w_sel_mask       = (r_state == ST_IDLE) ? ChEn_i : r_mask;

  ni_next_ch_sel #(
    .NumCh (NumCh),
    .IdxW  (IdxW)
  ) u_next_ch_sel (
    .i_mask       (w_sel_mask),
    .i_cur        (r_idx),
    .i_from_start (w_sel_from_start),
    .o_idx        (w_sel_idx),
    .o_found      (w_sel_found)
  );

  // Pick the current channel's snapshot (zero-extended) and destination port
  always_comb begin
    w_sample                = '0;
    w_sample[DataW-1:0]     = r_data[r_idx*DataW +: DataW];
    w_port                  = DstPorts[r_idx*PortW +: PortW];
  end

  // Next-state, capture strobe and flit output decode
  always_comb begin
    w_state_nxt = r_state;
    w_idx_nxt   = r_idx;
    w_seq_nxt   = r_seq;
    w_cap       = 1'b0;
    w_valid     = 1'b0;
    w_data      = '0;
    w_tv        = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (TokenValid_i) begin
          w_cap = 1'b1;
          if (w_sel_found) begin
            w_idx_nxt   = w_sel_idx;
            w_state_nxt = ST_HEAD;
          end else begin
            w_state_nxt = ST_PASS;
          end
        end else begin
          w_state_nxt = ST_IDLE;
        end
      end
      ST_HEAD: begin
        w_valid = 1'b1;
        w_data  = make_head(ID_i, w_port);
        if (Ready_i) begin
          w_state_nxt = ST_BODY;
        end else begin
          w_state_nxt = ST_HEAD;
        end
      end
      ST_BODY: begin
        w_valid = 1'b1;
        w_data  = make_body(w_sample);
        if (Ready_i) begin
          w_state_nxt = ST_TAIL;
        end else begin
          w_state_nxt = ST_BODY;
        end
      end
      ST_TAIL: begin
        w_valid = 1'b1;
        w_data  = make_tail(r_seq, w_sample[7:0]);
        if (Ready_i) begin
          if (w_sel_found) begin
            w_idx_nxt   = w_sel_idx;
            w_state_nxt = ST_HEAD;
          end else begin
            w_seq_nxt   = r_seq + 8'd1;
            w_tv        = 1'b1;
            w_state_nxt = ST_IDLE;
          end
        end else begin
          w_state_nxt = ST_TAIL;
        end
      end
      ST_PASS: begin
        w_tv        = 1'b1;
        w_state_nxt = ST_IDLE;
      end
      default: begin
        w_state_nxt = ST_IDLE;
      end
    endcase
  end

  // State register with synchronous reset; snapshot loads only on capture
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= ST_IDLE;
      r_idx   <= '0;
      r_seq   <= 8'd0;
      r_data  <= '0;
      r_mask  <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_idx   <= w_idx_nxt;
      r_seq   <= w_seq_nxt;
      if (w_cap) begin
        r_data <= Data_i;
        r_mask <= ChEn_i;
      end
    end
  end

  // Outputs are forced quiet while reset is held so an abandoned packet
  // never shows a flit or a token release in the reset cycle.
  assign Valid_o      = w_valid & ~rst;
  assign Data_o       = rst ? 32'd0 : w_data;
  assign TokenValid_o = w_tv & ~rst;
  assign Busy_o       = (r_state != ST_IDLE) & ~rst;

endmodule

// File: tb/tb_sensor_ni_multi.sv
// Directed bench for sensor_ni_multi with default parameters
// (2 channels, 24-bit samples, ch0 -> port 27, ch1 -> port 26).
module tb_sensor_ni_multi;

  logic        clk;
  logic        rst;
  logic [47:0] Data_i;
  logic [1:0]  ChEn_i;
  logic [3:0]  ID_i;
  logic        Valid_o;
  logic [31:0] Data_o;
  logic        Ready_i;
  logic        TokenValid_i;
  logic        TokenValid_o;
  logic        Busy_o;

  int n_vec;
  int n_err;

  sensor_ni_multi dut (
    .clk          (clk),
    .rst          (rst),
    .Data_i       (Data_i),
    .ChEn_i       (ChEn_i),
    .ID_i         (ID_i),
    .Valid_o      (Valid_o),
    .Data_o       (Data_o),
    .Ready_i      (Ready_i),
    .TokenValid_i (TokenValid_i),
    .TokenValid_o (TokenValid_o),
    .Busy_o       (Busy_o)
  );

  // 10 ns clock
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Single comparison point: counts every vector, reports miscompares
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %08h expected %08h", tag, obs, exp);
    end
  endtask

  // Advance to just after the next rising edge
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Check one flit at the falling edge, then move past the accepting edge
  task automatic expect_flit(input string tag, input logic [31:0] exp, input logic exp_tv);
    @(negedge clk);
    chk({tag, "_v"},  {31'd0, Valid_o},      32'd1);
    chk({tag, "_d"},  Data_o,                exp);
    chk({tag, "_tv"}, {31'd0, TokenValid_o}, {31'd0, exp_tv});
    step();
  endtask

  // Present a token for one cycle; DUT is still IDLE in that cycle
  task automatic send_token(input string tag);
    TokenValid_i = 1'b1;
    @(negedge clk);
    chk({tag, "_tokv"}, {31'd0, Valid_o}, 32'd0);
    step();
    TokenValid_i = 1'b0;
  endtask

  // Check the interface is idle after a round
  task automatic expect_idle(input string tag);
    @(negedge clk);
    chk({tag, "_busy"}, {31'd0, Busy_o},       32'd0);
    chk({tag, "_v"},    {31'd0, Valid_o},      32'd0);
    chk({tag, "_tv"},   {31'd0, TokenValid_o}, 32'd0);
  endtask

  // Unchecked single-channel round used to walk the sequence number
  task automatic quiet_round();
    TokenValid_i = 1'b1;
    step();
    TokenValid_i = 1'b0;
    repeat (3) step();
  endtask

  initial begin
    n_vec        = 0;
    n_err        = 0;
    rst          = 1'b1;
    Data_i       = {24'h123456, 24'hABCDEF};
    ChEn_i       = 2'b00;
    ID_i         = 4'h3;
    Ready_i      = 1'b0;
    TokenValid_i = 1'b0;

    // Reset state, while held and after release
    step();
    step();
    @(negedge clk);
    chk("rst_v",    {31'd0, Valid_o},      32'd0);
    chk("rst_d",    Data_o,                32'd0);
    chk("rst_tv",   {31'd0, TokenValid_o}, 32'd0);
    chk("rst_busy", {31'd0, Busy_o},       32'd0);
    step();
    rst     = 1'b0;
    Ready_i = 1'b1;
    @(negedge clk);
    chk("post_v",    {31'd0, Valid_o}, 32'd0);
    chk("post_d",    Data_o,           32'd0);
    chk("post_busy", {31'd0, Busy_o},  32'd0);
    step();

    // Both channels, continuous ready: six flits, release on the sixth
    ChEn_i = 2'b11;
    send_token("r0");
    expect_flit("r0_h0", 32'h2000007B, 1'b0);
    expect_flit("r0_b0", 32'h40ABCDEF, 1'b0);
    expect_flit("r0_t0", 32'hC00000EF, 1'b0);
    expect_flit("r0_h1", 32'h2000007A, 1'b0);
    expect_flit("r0_b1", 32'h40123456, 1'b0);
    expect_flit("r0_t1", 32'hC0000056, 1'b1);
    expect_idle("r0_end");
    step();

    // Only channel 1 enabled: one packet, sequence now 1
    ChEn_i = 2'b10;
    send_token("r1");
    expect_flit("r1_h1", 32'h2000007A, 1'b0);
    expect_flit("r1_b1", 32'h40123456, 1'b0);
    expect_flit("r1_t1", 32'hC0000156, 1'b1);
    expect_idle("r1_end");
    step();

    // Nothing enabled: release exactly one cycle after the token
    ChEn_i = 2'b00;
    send_token("r2");
    @(negedge clk);
    chk("r2_pass_v",    {31'd0, Valid_o},      32'd0);
    chk("r2_pass_d",    Data_o,                32'd0);
    chk("r2_pass_tv",   {31'd0, TokenValid_o}, 32'd1);
    chk("r2_pass_busy", {31'd0, Busy_o},       32'd1);
    step();
    expect_idle("r2_end");
    step();

    // Ready pattern 1-0-0-1 across the body flit; sequence still 2
    ChEn_i = 2'b01;
    send_token("r3");
    expect_flit("r3_h0", 32'h2000007B, 1'b0);
    Ready_i = 1'b0;
    expect_flit("r3_b0_s1", 32'h40ABCDEF, 1'b0);
    expect_flit("r3_b0_s2", 32'h40ABCDEF, 1'b0);
    Ready_i = 1'b1;
    expect_flit("r3_b0", 32'h40ABCDEF, 1'b0);
    expect_flit("r3_t0", 32'hC00002EF, 1'b1);
    expect_idle("r3_end");
    step();

    // Second token, new samples and mask mid-packet are all ignored
    ChEn_i = 2'b11;
    send_token("r4");
    expect_flit("r4_h0", 32'h2000007B, 1'b0);
    TokenValid_i = 1'b1;
    Data_i       = {24'h555555, 24'h999999};
    ChEn_i       = 2'b00;
    expect_flit("r4_b0", 32'h40ABCDEF, 1'b0);
    TokenValid_i = 1'b0;
    expect_flit("r4_t0", 32'hC00003EF, 1'b0);
    expect_flit("r4_h1", 32'h2000007A, 1'b0);
    expect_flit("r4_b1", 32'h40123456, 1'b0);
    expect_flit("r4_t1", 32'hC0000356, 1'b1);
    expect_idle("r4_end");
    step();

    // Walk the sequence from 4 up to 255, then check the wrap
    Data_i = {24'h123456, 24'hABCDEF};
    ChEn_i = 2'b01;
    for (int r = 0; r < 251; r++) begin
      quiet_round();
    end
    send_token("wff");
    expect_flit("wff_h0", 32'h2000007B, 1'b0);
    expect_flit("wff_b0", 32'h40ABCDEF, 1'b0);
    expect_flit("wff_t0", 32'hC000FFEF, 1'b1);
    step();
    send_token("w00");
    expect_flit("w00_h0", 32'h2000007B, 1'b0);
    expect_flit("w00_b0", 32'h40ABCDEF, 1'b0);
    expect_flit("w00_t0", 32'hC00001EF - 32'h00000100, 1'b1);
    step();

    // Reset during the body flit: packet abandoned, no release, sequence 0
    send_token("rb");
    expect_flit("rb_h0", 32'h2000007B, 1'b0);
    rst = 1'b1;
    @(negedge clk);
    chk("rb_rst_v",  {31'd0, Valid_o},      32'd0);
    chk("rb_rst_tv", {31'd0, TokenValid_o}, 32'd0);
    step();
    rst = 1'b0;
    expect_idle("rb_after");
    step();
    send_token("rs");
    expect_flit("rs_h0", 32'h2000007B, 1'b0);
    expect_flit("rs_b0", 32'h40ABCDEF, 1'b0);
    expect_flit("rs_t0", 32'hC00000EF, 1'b1);
    expect_idle("rs_end");

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
